// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the pushbutton debounce front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } key_state_t;

  // 10 ms stability window at 50 MHz
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Key bundle between the raw pushbuttons and the conditioned press/release outputs.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are fire-and-forget.
interface key_debounce_pulse_if #(
  parameter int N_KEYS = 2
);

  logic [N_KEYS-1:0] i_key_n;     // raw active-low buttons
  logic [N_KEYS-1:0] o_pressed;   // one-cycle press pulse
  logic [N_KEYS-1:0] o_released;  // one-cycle release pulse
  logic [N_KEYS-1:0] o_level;     // debounced level, 1 = held down

  // Board / stimulus side: drives the keys, consumes the pulses
  modport master (
    output i_key_n,
    input  o_pressed,
    input  o_released,
    input  o_level
  );

  // Conditioner side
  modport slave (
    input  i_key_n,
    output o_pressed,
    output o_released,
    output o_level
  );

endinterface

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, stability counter and press/release FSM with registered pulses.
// Latency: press/release pulse appears DEBOUNCE_CYCLES+3 edges after the raw input settles.
// Backpressure: none; each accepted edge yields exactly one single-cycle pulse.
module key_debounce_cell
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_released,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pressed;
  logic             r_released;
  logic             r_level;

  key_state_t       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pressed_nxt;
  logic             w_released_nxt;
  logic             w_level_nxt;

  // Synchroniser; resets to the released (high) level so reset never looks like a press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state logic: any disagreement during a wait state restarts from the stable state,
  // and the counter is cleared on every state entry so it can never wrap
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pressed_nxt  = 1'b0;
    w_released_nxt = 1'b0;
    w_level_nxt    = r_level;
    case (r_state)
      S_RELEASED: begin
        if (!r_sync2) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (r_sync2) begin
          w_state_nxt = S_RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt   = S_PRESSED;
          w_cnt_nxt     = '0;
          w_pressed_nxt = 1'b1;
          w_level_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (r_sync2) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (!r_sync2) begin
          w_state_nxt = S_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt    = S_RELEASED;
          w_cnt_nxt      = '0;
          w_released_nxt = 1'b1;
          w_level_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset drops any pulse about to be issued
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_RELEASED;
      r_cnt      <= '0;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
      r_level    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pressed  <= w_pressed_nxt;
      r_released <= w_released_nxt;
      r_level    <= w_level_nxt;
    end
  end

  assign o_pressed  = r_pressed;
  assign o_released = r_released;
  assign o_level    = r_level;

endmodule

// File: rtl/key_debounce_pulse.sv
// Pushbutton conditioner: N_KEYS independent debounce cells producing press/release pulses.
// Latency: DEBOUNCE_CYCLES+3 edges from a settled raw edge to the pulse, per key.
// Backpressure: none; o_pressed[0] feeds i_start and o_pressed[1] feeds i_prev_random downstream.
module key_debounce_pulse
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  key_debounce_pulse_if.slave   bus
);

  logic [N_KEYS-1:0] w_pressed;
  logic [N_KEYS-1:0] w_released;
  logic [N_KEYS-1:0] w_level;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_key_n    (bus.i_key_n[g]),
      .o_pressed  (w_pressed[g]),
      .o_released (w_released[g]),
      .o_level    (w_level[g])
    );
  end

  assign bus.o_pressed  = w_pressed;
  assign bus.o_released = w_released;
  assign bus.o_level    = w_level;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with a pulse scoreboard.
// Latency: expected pulse time computed at drive time as drive_cycle + DEB + 3.
// Backpressure: n/a.
module tb_key_debounce_pulse;

  localparam int NK  = 2;
  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  typedef struct packed {
    int   cyc;
    int   key;
    logic rel;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pcnt [NK];
  int   rcnt [NK];
  ev_t  sb [$];

  key_debounce_pulse_if #(.N_KEYS(NK)) kif ();

  key_debounce_pulse #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (kif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int key, input logic rel);
    ev_t e;
    e.cyc = cyc + LAT;
    e.key = key;
    e.rel = rel;
    sb.push_back(e);
  endtask

  // Pulse monitor: every observed pulse must match the next scoreboard entry exactly
  initial begin
    for (int k = 0; k < NK; k++) begin
      pcnt[k] = 0;
      rcnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        for (int k = 0; k < NK; k++) begin
          checks++;
          assert (!(kif.o_pressed[k] && kif.o_released[k])) else begin
            errors++;
            $error("FAIL both_pulses key%0d: observed pressed=released=1 expected not both (cycle %0d)", k, cyc);
          end
          if (kif.o_pressed[k] === 1'b1 || kif.o_released[k] === 1'b1) begin
            ev_t got;
            ev_t e;
            got.cyc = cyc;
            got.key = k;
            got.rel = kif.o_released[k];
            if (got.rel) rcnt[k]++; else pcnt[k]++;
            checks++;
            assert (sb.size() != 0) else begin
              errors++;
              $error("FAIL unexpected_pulse: observed key%0d rel=%0d cycle %0d expected no pulse", k, got.rel, cyc);
            end
            if (sb.size() != 0) begin
              e = sb.pop_front();
              checks++;
              assert (got === e) else begin
                errors++;
                $error("FAIL pulse: observed key%0d rel=%0d cycle %0d expected key%0d rel=%0d cycle %0d",
                       got.key, got.rel, got.cyc, e.key, e.rel, e.cyc);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int p0;
    int r0;
    kif.i_key_n = '1;
    rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pressed",  32'(kif.o_pressed),  32'h0);
    chk("rst_released", 32'(kif.o_released), 32'h0);
    chk("rst_level",    32'(kif.o_level),    32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press on key0
    kif.i_key_n[0] = 1'b0;
    push(0, 1'b0);
    repeat (LAT - 1) @(negedge clk);
    chk("t1_level_before", 32'(kif.o_level[0]), 32'h0);
    chk("t1_pulse_before", 32'(kif.o_pressed[0]), 32'h0);
    @(negedge clk);
    chk("t1_pulse", 32'(kif.o_pressed[0]), 32'h1);
    chk("t1_level", 32'(kif.o_level[0]), 32'h1);
    @(negedge clk);
    chk("t1_pulse_one_cycle", 32'(kif.o_pressed[0]), 32'h0);
    repeat (4) @(negedge clk);

    // Release of key0
    kif.i_key_n[0] = 1'b1;
    push(0, 1'b1);
    repeat (LAT - 1) @(negedge clk);
    chk("t3_level_held", 32'(kif.o_level[0]), 32'h1);
    @(negedge clk);
    chk("t3_released", 32'(kif.o_released[0]), 32'h1);
    chk("t3_level", 32'(kif.o_level[0]), 32'h0);
    chk("t3_no_press", 32'(kif.o_pressed[0]), 32'h0);
    repeat (5) @(negedge clk);

    // Bounce: short lows and highs never yield a pulse, final low does
    for (int i = 0; i < 2; i++) begin
      kif.i_key_n[0] = 1'b0;
      repeat (2) @(negedge clk);
      kif.i_key_n[0] = 1'b1;
      repeat (2) @(negedge clk);
    end
    chk("t2_level_during_bounce", 32'(kif.o_level[0]), 32'h0);
    kif.i_key_n[0] = 1'b0;
    push(0, 1'b0);
    repeat (10) @(negedge clk);
    chk("t2_level", 32'(kif.o_level[0]), 32'h1);
    kif.i_key_n[0] = 1'b1;
    push(0, 1'b1);
    repeat (10) @(negedge clk);

    // Long hold: exactly one press pulse, no release
    kif.i_key_n[0] = 1'b0;
    push(0, 1'b0);
    p0 = pcnt[0];
    r0 = rcnt[0];
    repeat (1000) @(negedge clk);
    chk("t4_press_count",   32'(pcnt[0] - p0), 32'd1);
    chk("t4_release_count", 32'(rcnt[0] - r0), 32'd0);
    chk("t4_level", 32'(kif.o_level[0]), 32'h1);
    kif.i_key_n[0] = 1'b1;
    push(0, 1'b1);
    repeat (10) @(negedge clk);

    // Both keys in the same cycle
    kif.i_key_n = 2'b00;
    push(0, 1'b0);
    push(1, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("t5_both_pressed", 32'(kif.o_pressed), 32'h3);
    @(negedge clk);
    chk("t5_both_cleared", 32'(kif.o_pressed), 32'h0);
    chk("t5_levels", 32'(kif.o_level), 32'h3);
    repeat (5) @(negedge clk);
    kif.i_key_n = 2'b11;
    push(0, 1'b1);
    push(1, 1'b1);
    repeat (10) @(negedge clk);
    chk("t5_levels_after", 32'(kif.o_level), 32'h0);

    // Reset in the middle of the press window, key kept down
    kif.i_key_n[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_pulse_in_reset", 32'(kif.o_pressed), 32'h0);
    chk("t6_level_in_reset", 32'(kif.o_level), 32'h0);
    rst = 1'b0;
    push(0, 1'b0);
    repeat (LAT) @(negedge clk);
    chk("t6_pulse_after_reset", 32'(kif.o_pressed[0]), 32'h1);
    repeat (3) @(negedge clk);
    kif.i_key_n[0] = 1'b1;
    push(0, 1'b1);
    repeat (12) @(negedge clk);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
